// File: rtl/bcd_digit_encoder.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One input bit is consumed per
// SHIFT cycle. bcd_out and over_range only change on the FINISH cycle, so the display never sees partial digits.
module bcd_digit_encoder #(
    parameter int BIN_W    = 12,
    parameter int DIGITS   = 4,
    parameter int SHOW_MAX = 999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  over_range
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] SHOW_MAX_B = BIN_W'(SHOW_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state;
    logic [BIN_W-1:0] shift_q;
    logic [BCD_W-1:0] acc_q;
    logic [BCD_W-1:0] acc_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             ovr_q;

    // Add-3 correction on every nibble >= 5, applied before each shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            over_range <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= bin_in;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(BIN_W);
                        ovr_q   <= (bin_in > SHOW_MAX_B);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc_q, shift_q} <= {acc_adj, shift_q} << 1;
                    cnt_q            <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_out    <= acc_q;
                    over_range <= ovr_q;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Bench for bcd_digit_encoder: directed boundary/protocol steps plus random and sweep
// conversions, scored against a decimal-digit reference model.
module tb_bcd_digit_encoder;

    localparam int W = 17;  // {over_range, bcd_out}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        over_range;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] hold_exp = '0;
    logic [W-1:0] mon_e;
    int           mon_c;

    bcd_digit_encoder #(.BIN_W(12), .DIGITS(4), .SHOW_MAX(999)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .over_range (over_range)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: decimal digits by plain arithmetic
    function automatic logic [W-1:0] ref_conv(input int v);
        logic [15:0] d;
        d = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        return {(v > 999), d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cyc_q.delete();
            hold_exp = '0;
        end else if (done) begin
            check("done_busy", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("result", 32'({over_range, bcd_out}), 32'(mon_e));
                check("done_cycle", 32'(cyc), 32'(mon_c));
                hold_exp = mon_e;
            end
        end else begin
            check("hold", 32'({over_range, bcd_out}), 32'(hold_exp));
        end
    end

    // driver tasks
    task automatic start_conv(input int v);
        bin_in = 12'(v);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(ref_conv(v));
        exp_cyc_q.push_back(cyc + 13);
    endtask

    task automatic wait_done(output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          bc;
    int          bv[3] = '{999, 1000, 4095};
    logic [16:0] bexp[3] = '{17'h00999, 17'h11000, 17'h14095};

    initial begin
        // reset
        rst_n = 1'b0;
        tick(3);
        check("reset_out", 32'({busy, done, over_range, bcd_out}), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // zero conversion, busy length
        start_conv(0);
        wait_done(bc);
        check("busy_len", 32'(bc), 32'd13);
        check("zero", 32'({over_range, bcd_out}), 32'd0);

        // boundaries
        for (int i = 0; i < 3; i++) begin
            tick(1);
            start_conv(bv[i]);
            wait_done(bc);
            check("boundary", 32'({over_range, bcd_out}), 32'(bexp[i]));
        end

        // start while busy and bin_in changes are ignored
        tick(1);
        start_conv(250);
        tick(4);
        bin_in = 12'd777;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        bin_in = 12'd3000;
        tick(3);
        bin_in = 12'($urandom);
        wait_done(bc);
        check("ignore_start", 32'(bcd_out), 32'h0250);
        tick(15);

        // back-to-back: start in the done cycle
        start_conv(456);
        wait_done(bc);
        start_conv(123);
        check("b2b_hold", 32'(bcd_out), 32'h0456);
        wait_done(bc);
        check("b2b_second", 32'(bcd_out), 32'h0123);

        // asynchronous reset mid-conversion
        tick(1);
        start_conv(888);
        wait_done(bc);
        check("pre_reset", 32'(bcd_out), 32'h0888);
        start_conv(321);
        tick(6);
        rst_n = 1'b0;
        #1;
        check("rst_mid", 32'({busy, done, over_range, bcd_out}), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(15);
        start_conv(42);
        wait_done(bc);
        check("post_reset", 32'({over_range, bcd_out}), 32'h00042);

        // random values with random idle gaps
        for (int i = 0; i < 40; i++) begin
            tick($urandom_range(1, 4));
            start_conv($urandom_range(0, 4095));
            wait_done(bc);
        end

        // exhaustive back-to-back sweep
        for (int v = 0; v < 4096; v++) begin
            start_conv(v);
            wait_done(bc);
        end

        // final report
        tick(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
